// File: rtl/p_uart_recv.sv
// Packet UART receiver: deserialises 8N1 frames (LSB first) and assembles
// eight consecutive bytes into one 64-bit word, byte k at [8k+7:8k].
module p_uart_recv #(
    parameter int CLK_FREQ     = 50000000,
    parameter int UART_BPS     = 9600,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        uart_rxd,
    output logic [63:0] uart_dout,
    output logic        uart_done,
    output logic        rx_busy,
    output logic [3:0]  rx_cnt,
    output logic        frame_err,
    output logic        timeout_err
);

    localparam int BPS_CNT      = CLK_FREQ / UART_BPS;
    localparam int HALF         = BPS_CNT / 2;
    localparam int TIMEOUT_CLKS = TIMEOUT_BITS * BPS_CNT;
    localparam int CNT_W        = $clog2(BPS_CNT + 1);
    localparam int TO_W         = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic              rx_s1_q, rx_s2_q, rx_prev_q;
    logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [63:0]       shadow_q, shadow_d;
    logic [3:0]        rx_cnt_q, rx_cnt_d;
    logic [63:0]       dout_q, dout_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;
    logic              terr_q, terr_d;
    logic              busy_q, busy_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              start_edge_s;

    assign uart_dout   = dout_q;
    assign uart_done   = done_q;
    assign rx_busy     = busy_q;
    assign rx_cnt      = rx_cnt_q;
    assign frame_err   = ferr_q;
    assign timeout_err = terr_q;

    // Next-state logic for the bit FSM, packet assembly and the inter-byte timeout
    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q + CNT_W'(1);
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        shadow_d     = shadow_q;
        rx_cnt_d     = rx_cnt_q;
        dout_d       = dout_q;
        done_d       = 1'b0;
        ferr_d       = 1'b0;
        terr_d       = 1'b0;
        to_cnt_d     = to_cnt_q;
        start_edge_s = rx_prev_q & ~rx_s2_q;

        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (start_edge_s) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (clk_cnt_q == CNT_W'(HALF - 1)) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = 3'd0;
                    if (!rx_s2_q) begin
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                // Samples land mid-bit because the start bit was sampled at its centre
                if (clk_cnt_q == CNT_W'(BPS_CNT - 1)) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (clk_cnt_q == CNT_W'(BPS_CNT - 1)) begin
                    clk_cnt_d = '0;
                    state_d   = IDLE;
                    if (rx_s2_q) begin
                        shadow_d[{rx_cnt_q[2:0], 3'b000} +: 8] = shift_q;
                        if (rx_cnt_q == 4'd7) begin
                            dout_d   = shadow_d;
                            done_d   = 1'b1;
                            rx_cnt_d = 4'd0;
                        end else begin
                            rx_cnt_d = rx_cnt_q + 4'd1;
                        end
                    end else begin
                        ferr_d   = 1'b1;
                        rx_cnt_d = 4'd0;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d   = IDLE;
                clk_cnt_d = '0;
            end
        endcase

        // Expiry takes precedence over a coincident start edge
        if ((state_q == IDLE) && (rx_cnt_q != 4'd0)) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CLKS - 1)) begin
                terr_d   = 1'b1;
                rx_cnt_d = 4'd0;
                to_cnt_d = '0;
            end else if (start_edge_s) begin
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end else begin
            to_cnt_d = '0;
        end

        busy_d = (state_d != IDLE);
    end

    // State registers with synchronous reset; synchroniser idles high
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            shadow_q  <= 64'd0;
            rx_cnt_q  <= 4'd0;
            dout_q    <= 64'd0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            terr_q    <= 1'b0;
            busy_q    <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            rx_s1_q   <= uart_rxd;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            shadow_q  <= shadow_d;
            rx_cnt_q  <= rx_cnt_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            terr_q    <= terr_d;
            busy_q    <= busy_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

endmodule

// File: doc/p_uart_recv.md
Name: p_uart_recv

Overview:
Packet UART receiver, the receive-side counterpart of the 64-bit packet UART sender. It deserialises 8N1 frames on uart_rxd, LSB first, and assembles eight consecutive bytes into one 64-bit word. Byte 0 lands in [7:0] and byte 7 in [63:56]. It sits between the board RX pin and user logic, and contains its own bit-level receiver (no sub-module).

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
UART_BPS, 9600, baud rate
TIMEOUT_BITS, 20, inter-byte idle limit in bit periods before a partial packet is dropped

Ports:
sys_clk  input  1  system clock
sys_rst  input  1  synchronous reset, active-high
uart_rxd  input  1  serial line, asynchronous, idle high
uart_dout  output  64  last complete packet, byte k at [8k+7:8k]
uart_done  output  1  one-cycle pulse when uart_dout is updated
rx_busy  output  1  high while a frame is being received (state != IDLE)
rx_cnt  output  4  bytes of the current packet received so far, 0..7
frame_err  output  1  one-cycle pulse on bad stop bit
timeout_err  output  1  one-cycle pulse when a partial packet is dropped

Behaviour:
- Constants: BPS_CNT = CLK_FREQ/UART_BPS (integer division); HALF = BPS_CNT/2; TIMEOUT_CLKS = TIMEOUT_BITS*BPS_CNT.
- Reset (sys_rst=1 at a sys_clk edge, takes priority over everything):
  - uart_dout=0, uart_done=0, rx_busy=0, rx_cnt=0, frame_err=0, timeout_err=0.
  - State=IDLE, shadow buffer=0, all counters 0, synchroniser flops=1.
  - Reset mid-frame abandons the frame and the partial packet silently.
- Input: uart_rxd passes through a 2-FF synchroniser. A start is the synchronised falling edge (prev=1, cur=0) seen in IDLE.
- FSM states IDLE, START, DATA, STOP. The clk counter clears on each state entry and on each bit boundary.
  - IDLE -> START on a start edge.
  - START: at clk_cnt==HALF-1, sample the line. If 0 -> DATA with the bit counter cleared. If 1 -> glitch, go to IDLE with no error.
  - DATA: sample at every HALF+BPS_CNT*k point (the middle of each bit). Shift LSB first. After the 8th sample -> STOP.
  - STOP: sample at mid-bit, then go to IDLE in the next cycle, so a back-to-back start edge half a bit later is caught.
- Stop sample = 1 (byte good):
  - Write the byte into shadow[8*rx_cnt +: 8].
  - If rx_cnt==7: copy shadow, including the new byte, into uart_dout; pulse uart_done; rx_cnt->0. Both happen one cycle after the stop sample.
  - Otherwise rx_cnt increments.
- Stop sample = 0: pulse frame_err, discard the byte, set rx_cnt->0, leave uart_dout unchanged.
- Timeout counter:
  - Runs only when state==IDLE and rx_cnt!=0.
  - Clears on a start edge, on reset, and whenever rx_cnt==0.
  - When it reaches TIMEOUT_CLKS-1: pulse timeout_err, set rx_cnt->0, clear the counter.
  - If a start edge arrives in the same cycle as expiry, the timeout wins and the new frame becomes byte 0.
- Pulse exclusivity: uart_done, frame_err and timeout_err are mutually exclusive and never exceed 1 cycle.
- Holding: uart_dout holds its value until the next complete packet. Downstream logic must capture it on uart_done.
- Line stuck low after a frame_err: there is no new falling edge, so the receiver stays in IDLE.

Test Plan:
Use CLK_FREQ=1000000, UART_BPS=100000 (BPS_CNT=10, HALF=5) and TIMEOUT_BITS=20 for all scenarios.
1. Send bytes 0x01..0x08 back-to-back, one stop bit each -> exactly one uart_done pulse, uart_dout=64'h0807060504030201, rx_cnt walks 1..7 then 0, no error pulses.
2. Drive uart_rxd low for 3 clocks, then high -> FSM leaves START for IDLE, no error pulses, rx_cnt unchanged.
3. Send 0xAA, 0x55, then 0x33 with the stop bit forced to 0 -> frame_err pulses once, rx_cnt=0, uart_dout unchanged. A following full 8-byte packet of 0x11..0x88 -> uart_dout=64'h8877665544332211.
4. Send 3 bytes, then hold the line high -> timeout_err pulses exactly 200 clocks after the third byte's STOP->IDLE transition, rx_cnt=0. A following 8-byte packet decodes correctly.
5. Assert sys_rst during the DATA bits of byte 5 -> every output is 0 on the next cycle. The next full packet decodes correctly with no stale shadow bytes.
6. Send two packets back-to-back -> two uart_done pulses 80 bit periods apart; uart_dout shows the first packet, then the second.
